// File: rtl/aha_sram_arb2.sv
// Two-port round-robin arbiter and command sequencer for a single-port SRAM wrapper.
// Optional zero-fill after reset: define AHA_SRAM_ARB_ZERO_INIT_EN.
//
// state   | meaning
// ST_INIT | writing zero to every address, requesters held off
// ST_RUN  | normal arbitration of port 0 / port 1 traffic
module aha_sram_arb2 #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 64,
  localparam int STRB_W = DATA_W / 8
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic              p0_valid,
  output logic              p0_ready,
  input  logic              p0_write,
  input  logic [STRB_W-1:0] p0_strb,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_valid,
  output logic              p1_ready,
  input  logic              p1_write,
  input  logic [STRB_W-1:0] p1_strb,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              init_done,
  output logic              sram_cen,
  output logic [STRB_W-1:0] sram_wen,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_d,
  input  logic [DATA_W-1:0] sram_q
);

  logic              run;
  logic              fill;
  logic [ADDR_W-1:0] fill_addr;
  logic              rr_ptr;
  logic              rd_v1;
  logic              rd_p1;
  logic              sel_write;
  logic [STRB_W-1:0] sel_strb;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

`ifdef AHA_SRAM_ARB_ZERO_INIT_EN
  typedef enum logic {ST_INIT, ST_RUN} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fill    = 1'b0;
    case (state_q)
      ST_INIT: begin
        fill  = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) state_d = ST_RUN;
      end
      ST_RUN: ;
      default: state_d = ST_INIT;
    endcase
  end

  assign run       = (state_q == ST_RUN);
  assign fill_addr = cnt_q;
`else
  logic done_q;

  always_ff @(posedge CLK) begin
    if (!RESETn) done_q <= 1'b0;
    else         done_q <= 1'b1;
  end

  assign run       = done_q;
  assign fill      = 1'b0;
  assign fill_addr = '0;
`endif

  assign init_done = run;

  // rr_ptr names the port that wins when both are valid (0 = port 0)
  assign p0_ready = run & p0_valid & (~p1_valid | ~rr_ptr);
  assign p1_ready = run & p1_valid & (~p0_valid |  rr_ptr);

  always_comb begin
    sel_write = p0_write;
    sel_strb  = p0_strb;
    sel_addr  = p0_addr;
    sel_wdata = p0_wdata;
    if (p1_ready) begin
      sel_write = p1_write;
      sel_strb  = p1_strb;
      sel_addr  = p1_addr;
      sel_wdata = p1_wdata;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      sram_cen  <= 1'b1;
      sram_wen  <= '1;
      sram_a    <= '0;
      sram_d    <= '0;
      rr_ptr    <= 1'b0;
      rd_v1     <= 1'b0;
      rd_p1     <= 1'b0;
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
    end else begin
      sram_cen <= 1'b1;
      sram_wen <= '1;
      rd_v1    <= 1'b0;
      if (fill) begin
        sram_cen <= 1'b0;
        sram_wen <= '0;
        sram_a   <= fill_addr;
        sram_d   <= '0;
      end else if (p0_ready || p1_ready) begin
        sram_a <= sel_addr;
        sram_d <= sel_wdata;
        // next preference goes to whichever port did not just win
        rr_ptr <= p0_ready;
        if (!sel_write) begin
          sram_cen <= 1'b0;
          rd_v1    <= 1'b1;
          rd_p1    <= p1_ready;
        end else if (|sel_strb) begin
          sram_cen <= 1'b0;
          sram_wen <= ~sel_strb;
        end
      end
      p0_rvalid <= rd_v1 & ~rd_p1;
      p1_rvalid <= rd_v1 &  rd_p1;
    end
  end

  assign p0_rdata = p0_rvalid ? sram_q : '0;
  assign p1_rdata = p1_rvalid ? sram_q : '0;

endmodule
